// File: rtl/free_list_ctrl_pkg.sv
// Shared sizing parameters and state type for the physical-register free list.
// The pointer helper wraps circular-queue indices at FL_DEPTH.
package params;
  localparam int P_REG_SIZE = 128;
  localparam int A_REG_SIZE = 32;
  localparam int P_WIDTH    = 7;
  localparam int FL_DEPTH   = P_REG_SIZE - A_REG_SIZE;
  localparam int SCAN_WIDTH = 4;
  localparam int NUM_GROUPS = P_REG_SIZE / SCAN_WIDTH;
  localparam int SCAN_IDX_W = $clog2(NUM_GROUPS);
  localparam int CNT_W      = $clog2(SCAN_WIDTH + 1);

  // Advance a queue pointer by up to SCAN_WIDTH slots, wrapping past FL_DEPTH-1.
  function automatic logic [P_WIDTH-1:0] ptr_add(input logic [P_WIDTH-1:0] ptr,
                                                 input logic [CNT_W-1:0]   inc);
    logic [P_WIDTH:0] sum;
    sum = {1'b0, ptr} + (P_WIDTH+1)'(inc);
    if (sum >= (P_WIDTH+1)'(FL_DEPTH)) sum = sum - (P_WIDTH+1)'(FL_DEPTH);
    return sum[P_WIDTH-1:0];
  endfunction
endpackage

package rv32i_types;
  typedef enum logic {READY, REBUILD} fl_state_t;
endpackage

// File: rtl/free_list_ctrl_scan.sv
// Combinational decode of one SCAN_WIDTH-bit group of the backup bitmap:
// per-slot valid flag, absolute register index, and the number of set bits.
module free_scan
  import params::*;
(
  input  logic [SCAN_WIDTH-1:0]              bits,
  input  logic [P_WIDTH-1:0]                 base,
  output logic [SCAN_WIDTH-1:0]              slot_valid,
  output logic [SCAN_WIDTH-1:0][P_WIDTH-1:0] slot_idx,
  output logic [CNT_W-1:0]                   popcount
);
  assign slot_valid = bits;

  always_comb begin
    popcount = '0;
    for (int j = 0; j < SCAN_WIDTH; j++) begin
      slot_idx[j] = base + P_WIDTH'(j);
      popcount    = popcount + CNT_W'(bits[j]);
    end
  end
endmodule

// File: rtl/free_list_ctrl.sv
// Circular free list of physical registers, refilled after a flush by scanning
// the RRAT backup bitmap SCAN_WIDTH bits per cycle.
module free_list_ctrl
  import params::*;
  import rv32i_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  output logic                  alloc_ready,
  output logic [P_WIDTH-1:0]    alloc_pd,
  input  logic                  free_valid,
  input  logic [P_WIDTH-1:0]    free_pd,
  input  logic                  flush,
  input  logic [P_REG_SIZE-1:0] backup_free_list,
  output logic                  busy,
  output logic [P_WIDTH-1:0]    free_count,
  output logic                  overflow_err
);
  logic [P_WIDTH-1:0]    queue [FL_DEPTH];
  logic [P_WIDTH-1:0]    head, tail;
  fl_state_t             state;
  logic [P_REG_SIZE-1:0] snapshot;
  logic [SCAN_IDX_W-1:0] scan_idx;

  logic [P_WIDTH-1:0]                 scan_base, space;
  logic [SCAN_WIDTH-1:0]              scan_bits, slot_valid;
  logic [SCAN_WIDTH-1:0][P_WIDTH-1:0] slot_idx;
  logic [SCAN_WIDTH-1:0][CNT_W-1:0]   rank;
  logic [CNT_W-1:0]                   popcount, accepted;
  logic                               scan_overflow;
  logic                               alloc_fire, free_ok, full, free_accept, free_drop;

  assign scan_base = P_WIDTH'(32'(scan_idx) * SCAN_WIDTH);
  assign scan_bits = snapshot[scan_base +: SCAN_WIDTH];

  free_scan u_scan (
    .bits       (scan_bits),
    .base       (scan_base),
    .slot_valid (slot_valid),
    .slot_idx   (slot_idx),
    .popcount   (popcount)
  );

  // Each set bit lands at tail+rank; ranks past the remaining space are dropped.
  always_comb begin
    rank[0] = '0;
    for (int j = 1; j < SCAN_WIDTH; j++)
      rank[j] = rank[j-1] + CNT_W'(slot_valid[j-1]);
  end

  assign space         = P_WIDTH'(FL_DEPTH) - free_count;
  assign scan_overflow = P_WIDTH'(popcount) > space;
  assign accepted      = scan_overflow ? space[CNT_W-1:0] : popcount;

  assign alloc_ready = (state == READY) && !flush && (free_count != '0);
  assign alloc_pd    = queue[head];
  assign busy        = (state == REBUILD);
  assign alloc_fire  = alloc_req && alloc_ready;
  assign free_ok     = (state == READY) && !flush && free_valid && (free_pd != '0);
  assign full        = (free_count == P_WIDTH'(FL_DEPTH));
  assign free_accept = free_ok && (!full || alloc_fire);
  assign free_drop   = free_ok && full && !alloc_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) queue[i] <= P_WIDTH'(A_REG_SIZE + i);
      head         <= '0;
      tail         <= '0;
      free_count   <= P_WIDTH'(FL_DEPTH);
      state        <= READY;
      overflow_err <= 1'b0;
      snapshot     <= '0;
      scan_idx     <= '0;
    end else if (flush) begin
      snapshot   <= backup_free_list;
      head       <= '0;
      tail       <= '0;
      free_count <= '0;
      scan_idx   <= '0;
      state      <= REBUILD;
    end else if (state == REBUILD) begin
      for (int j = 0; j < SCAN_WIDTH; j++)
        if (slot_valid[j] && (P_WIDTH'(rank[j]) < space))
          queue[ptr_add(tail, rank[j])] <= slot_idx[j];
      tail       <= ptr_add(tail, accepted);
      free_count <= free_count + P_WIDTH'(accepted);
      if (scan_overflow) overflow_err <= 1'b1;
      scan_idx <= scan_idx + SCAN_IDX_W'(1);
      if (scan_idx == SCAN_IDX_W'(NUM_GROUPS - 1)) state <= READY;
    end else begin
      if (alloc_fire) head <= ptr_add(head, CNT_W'(1));
      if (free_accept) begin
        queue[tail] <= free_pd;
        tail        <= ptr_add(tail, CNT_W'(1));
      end
      case ({alloc_fire, free_accept})
        2'b10:   free_count <= free_count - P_WIDTH'(1);
        2'b01:   free_count <= free_count + P_WIDTH'(1);
        default: ;
      endcase
      if (free_drop) overflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_free_list_ctrl.sv
// Self-checking bench for free_list_ctrl: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_free_list_ctrl;
  import params::*;

  logic         clk = 1'b0;
  logic         rst, alloc_req, free_valid, flush;
  logic [6:0]   free_pd;
  logic [127:0] backup_free_list;
  logic         alloc_ready, busy, overflow_err;
  logic [6:0]   alloc_pd, free_count;

  always #5 clk = ~clk;

  free_list_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_req        (alloc_req),
    .alloc_ready      (alloc_ready),
    .alloc_pd         (alloc_pd),
    .free_valid       (free_valid),
    .free_pd          (free_pd),
    .flush            (flush),
    .backup_free_list (backup_free_list),
    .busy             (busy),
    .free_count       (free_count),
    .overflow_err     (overflow_err)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: a plain queue of free register numbers plus rebuild progress.
  int           m_q[$];
  bit           m_rebuild = 1'b0;
  int           m_group   = 0;
  logic [127:0] m_snap    = '0;
  bit           m_ovf     = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkModel();
    bit exp_ready;
    exp_ready = !m_rebuild && !flush && (m_q.size() != 0);
    checkOutput("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
    if (exp_ready) checkOutput("alloc_pd", 32'(alloc_pd), m_q[0]);
    checkOutput("busy", 32'(busy), 32'(m_rebuild));
    checkOutput("free_count", 32'(free_count), m_q.size());
    checkOutput("overflow_err", 32'(overflow_err), 32'(m_ovf));
  endtask

  task automatic modelEdge();
    bit fire, accept, attempt;
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < 96; i++) m_q.push_back(32 + i);
      m_ovf = 1'b0; m_rebuild = 1'b0; m_group = 0; m_snap = '0;
    end else if (flush) begin
      m_q.delete();
      m_snap = backup_free_list; m_rebuild = 1'b1; m_group = 0;
    end else if (m_rebuild) begin
      for (int b = m_group * 4; b < m_group * 4 + 4; b++)
        if (m_snap[7'(b)]) begin
          if (m_q.size() < 96) m_q.push_back(b);
          else m_ovf = 1'b1;
        end
      m_group++;
      if (m_group == 32) m_rebuild = 1'b0;
    end else begin
      fire    = alloc_req && (m_q.size() != 0);
      attempt = free_valid && (free_pd != 7'd0);
      accept  = attempt && ((m_q.size() < 96) || fire);
      if (fire) void'(m_q.pop_front());
      if (accept) m_q.push_back(int'(free_pd));
      if (attempt && !accept) m_ovf = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit a, input bit fv, input logic [6:0] pd,
                               input bit fl, input logic [127:0] bk, input bit chk);
    rst = r; alloc_req = a; free_valid = fv; free_pd = pd; flush = fl; backup_free_list = bk;
    #1;
    if (chk) checkModel();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  logic [127:0] bk;

  initial begin
    rst = 1'b1; alloc_req = 1'b0; free_valid = 1'b0; free_pd = '0; flush = 1'b0;
    backup_free_list = '0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 1'b1, '1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 1'b0, '0, 1'b0);
    checkOutput("rst_ready", 32'(alloc_ready), 32'd1);
    checkOutput("rst_pd", 32'(alloc_pd), 32'd32);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count", 32'(free_count), 32'd96);

    // Three allocations in a row.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 7'd0, 1'b0, '0, 1'b1);
    checkOutput("alloc3_pd", 32'(alloc_pd), 32'd35);
    checkOutput("alloc3_count", 32'(free_count), 32'd93);

    // Drain to empty, then a free while alloc_req is held.
    for (int i = 0; i < 93; i++) applyStimulus(1'b0, 1'b1, 1'b0, 7'd0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 7'd40, 1'b0, '0, 1'b1);
    checkOutput("empty_free_pd", 32'(alloc_pd), 32'd40);
    checkOutput("empty_free_count", 32'(free_count), 32'd1);

    // Free into a full queue, with and without a simultaneous allocation.
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd50, 1'b0, '0, 1'b1);
    checkOutput("full_drop_ovf", 32'(overflow_err), 32'd1);
    checkOutput("full_drop_count", 32'(free_count), 32'd96);
    applyStimulus(1'b0, 1'b1, 1'b1, 7'd50, 1'b0, '0, 1'b1);
    checkOutput("full_swap_count", 32'(free_count), 32'd96);
    checkOutput("full_swap_pd", 32'(alloc_pd), 32'd33);

    // Rebuild from bits 5,6,7,100; traffic during rebuild is ignored.
    bk = '0; bk[5] = 1'b1; bk[6] = 1'b1; bk[7] = 1'b1; bk[100] = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 7'd60, 1'b1, bk, 1'b1);
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b1, 1'b1, 7'd60, 1'b0, '0, 1'b1);
    checkOutput("rebuild_busy", 32'(busy), 32'd0);
    checkOutput("rebuild_count", 32'(free_count), 32'd4);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 7'd0, 1'b0, '0, 1'b1);
    checkOutput("rebuild_empty", 32'(free_count), 32'd0);

    // Second flush mid-rebuild restarts from the new snapshot.
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 128'hF, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, '0, 1'b1);
    bk = '0; bk[9] = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b1, bk, 1'b1);
    for (int i = 0; i < 31; i++) applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, '0, 1'b1);
    checkOutput("restart_still_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, '0, 1'b1);
    checkOutput("restart_pd", 32'(alloc_pd), 32'd9);
    checkOutput("restart_count", 32'(free_count), 32'd1);

    // A zero register return is ignored.
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd0, 1'b0, '0, 1'b1);
    checkOutput("zero_free_count", 32'(free_count), 32'd1);

    // All-ones snapshot overflows the 96-entry queue.
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b1, '1, 1'b1);
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, '0, 1'b1);
    checkOutput("snap_ovf", 32'(overflow_err), 32'd1);
    checkOutput("snap_count", 32'(free_count), 32'd96);
    checkOutput("snap_pd", 32'(alloc_pd), 32'd0);

    // Reset aborts a rebuild, and dominates a concurrent flush.
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b1, '0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 1'b1, '1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, '0, 1'b0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_count", 32'(free_count), 32'd96);
    checkOutput("abort_pd", 32'(alloc_pd), 32'd32);
    checkOutput("abort_ready", 32'(alloc_ready), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
                    ($urandom_range(0, 63) == 0),
                    {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
